// File: rtl/cmos_pwr_seq.sv
// cmos_pwr_seq: OV5640 power-up / reset sequencer.
// Waits for the camera PLL to lock, then walks the camera through the
// PWDN -> RESETB -> SCCB timing. It then kicks the SCCB config engine and
// reports ready, or reports fault once the configuration attempts run out.
// Optional XCLK gating is enabled by defining CMOS_PWR_SEQ_XCLK_GATE_EN.
// Without that macro, xclk_en is tied high for boards with a free-running XCLK.
module cmos_pwr_seq #(
    parameter int unsigned T_PWDN_CYC = 27000,
    parameter int unsigned T_RST_CYC  = 27000,
    parameter int unsigned T_SCCB_CYC = 540000,
    parameter int unsigned T_CFG_TO   = 1048575,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       cfg_done,
    output logic       xclk_en,
    output logic       cmos_pwdn,
    output logic       cmos_rst_n,
    output logic       cfg_start,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_cnt
);

    typedef enum logic [2:0] {
        IDLE, PWDN_WAIT, RST_WAIT, SCCB_WAIT, CFG, RUN, FAULT
    } state_t;

    // Terminal counts: a timed state exits on the edge where cnt == T-1.
    localparam logic [CNT_W-1:0] LIM_PWDN = CNT_W'(T_PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] LIM_RST  = CNT_W'(T_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LIM_SCCB = CNT_W'(T_SCCB_CYC - 1);
    localparam logic [CNT_W-1:0] LIM_TO   = CNT_W'(T_CFG_TO - 1);
    localparam logic [2:0]       RETRY_MX = 3'(MAX_RETRY);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_m;
    logic             lock_s;
    logic [2:0]       retry_nxt;
    logic             lock_lost;

    assign retry_nxt = retry_cnt + 3'd1;
    // Lock loss only matters while a sequence is in flight. FAULT latches
    // until reset.
    assign lock_lost = !lock_s && (state != IDLE) && (state != FAULT);

`ifndef CMOS_PWR_SEQ_XCLK_GATE_EN
    assign xclk_en = 1'b1;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // Sequencer FSM. All pin outputs are registered and change only on
    // state transitions.
    always_ff @(posedge clk) begin
        if (!rst_n || lock_lost) begin
            state      <= IDLE;
            cnt        <= '0;
`ifdef CMOS_PWR_SEQ_XCLK_GATE_EN
            xclk_en    <= 1'b0;
`endif
            cmos_pwdn  <= 1'b1;
            cmos_rst_n <= 1'b0;
            cfg_start  <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
            retry_cnt  <= 3'd0;
        end else begin
            cfg_start <= 1'b0;
            cnt       <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (lock_s) begin
`ifdef CMOS_PWR_SEQ_XCLK_GATE_EN
                        xclk_en <= 1'b1;
`endif
                        state <= PWDN_WAIT;
                    end
                end
                PWDN_WAIT: begin
                    if (cnt == LIM_PWDN) begin
                        cnt       <= '0;
                        cmos_pwdn <= 1'b0;
                        state     <= RST_WAIT;
                    end
                end
                RST_WAIT: begin
                    if (cnt == LIM_RST) begin
                        cnt        <= '0;
                        cmos_rst_n <= 1'b1;
                        state      <= SCCB_WAIT;
                    end
                end
                SCCB_WAIT: begin
                    if (cnt == LIM_SCCB) begin
                        cnt       <= '0;
                        cfg_start <= 1'b1;
                        state     <= CFG;
                    end
                end
                CFG: begin
                    // cfg_done beats a coincident timeout.
                    if (cfg_done) begin
                        cnt   <= '0;
                        ready <= 1'b1;
                        state <= RUN;
                    end else if (cnt == LIM_TO) begin
                        cnt        <= '0;
                        retry_cnt  <= retry_nxt;
                        cmos_pwdn  <= 1'b1;
                        cmos_rst_n <= 1'b0;
                        if (retry_nxt < RETRY_MX) begin
                            state <= PWDN_WAIT;
                        end else begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end
                    end
                end
                RUN, FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_pwr_seq.sv
// tb_cmos_pwr_seq: scenario-driven bench for cmos_pwr_seq. Each scenario
// pushes timestamped expected output vectors into a scoreboard queue. A
// negedge monitor pops each entry in its due cycle and compares it.
module tb_cmos_pwr_seq;

    localparam int T_PWDN = 4;
    localparam int T_RST  = 3;
    localparam int T_SCCB = 5;
    localparam int T_TO   = 10;
    localparam int MAXR   = 2;

`ifdef CMOS_PWR_SEQ_XCLK_GATE_EN
    localparam logic XR = 1'b0;
`else
    localparam logic XR = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       cfg_done;
    logic       xclk_en, cmos_pwdn, cmos_rst_n, cfg_start, ready, fault;
    logic [2:0] retry_cnt;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         at;
        string      tag;
        logic [8:0] val;
    } sb_t;
    sb_t sb[$];

    cmos_pwr_seq #(
        .T_PWDN_CYC(T_PWDN), .T_RST_CYC(T_RST), .T_SCCB_CYC(T_SCCB),
        .T_CFG_TO(T_TO), .MAX_RETRY(MAXR), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .cfg_done(cfg_done),
        .xclk_en(xclk_en), .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n),
        .cfg_start(cfg_start), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output vector: {xclk_en, pwdn, rst_n, cfg_start, ready, fault, retry[2:0]}
    function automatic logic [8:0] v(logic x, logic p, logic r, logic s,
                                     logic rd, logic f, logic [2:0] rc);
        return {x, p, r, s, rd, f, rc};
    endfunction

    localparam logic [8:0] RSTV = {XR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %b want %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic expv(input int at, input string tag, input logic [8:0] val);
        sb_t e;
        e.at = at; e.tag = tag; e.val = val;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Pulse rst_n for one edge with lock held high. Returns N such that the
    // sequencer sees lock at edge N+2, the same timing as a lock rising
    // just before edge N.
    task automatic restart(output int n);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = cyc + 1;
    endtask

    // Scoreboard monitor: compare every entry that falls due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                if (sb[i].at == cyc)
                    chk(sb[i].tag, {xclk_en, cmos_pwdn, cmos_rst_n, cfg_start,
                                    ready, fault, retry_cnt}, sb[i].val);
                else
                    chk({sb[i].tag, "_late"}, 9'h000, sb[i].val | 9'h100);
                sb.delete(i);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; pll_lock = 1'b0; cfg_done = 1'b0;
        wait_cyc(3);
        expv(4, "reset", RSTV);
        wait_cyc(4);
        rst_n = 1'b1;
        expv(9, "idle_nolock", RSTV);

        // 1: nominal bring-up
        wait_cyc(10);
        pll_lock = 1'b1; n = cyc + 1;
        expv(n+1,  "s1_pre",    RSTV);
        expv(n+2,  "s1_xclk",   v(1,1,0,0,0,0,0));
        expv(n+5,  "s1_pwdn_h", v(1,1,0,0,0,0,0));
        expv(n+6,  "s1_pwdn_l", v(1,0,0,0,0,0,0));
        expv(n+8,  "s1_rst_l",  v(1,0,0,0,0,0,0));
        expv(n+9,  "s1_rst_h",  v(1,0,1,0,0,0,0));
        expv(n+13, "s1_sccb",   v(1,0,1,0,0,0,0));
        expv(n+14, "s1_start",  v(1,0,1,1,0,0,0));
        expv(n+15, "s1_start0", v(1,0,1,0,0,0,0));
        expv(n+16, "s1_nordy",  v(1,0,1,0,0,0,0));
        expv(n+17, "s1_ready",  v(1,0,1,0,1,0,0));
        expv(n+30, "s1_run",    v(1,0,1,0,1,0,0));
        wait_cyc(n+16); cfg_done = 1'b1;
        wait_cyc(n+17); cfg_done = 1'b0;
        wait_cyc(n+32);

        // 2: single timeout, success on replay, then lock loss clears retry
        restart(n);
        expv(n+1,  "s2_pre",    RSTV);
        expv(n+14, "s2_start",  v(1,0,1,1,0,0,0));
        expv(n+23, "s2_cfg",    v(1,0,1,0,0,0,0));
        expv(n+24, "s2_to",     v(1,1,0,0,0,0,1));
        expv(n+28, "s2_pwdn",   v(1,0,0,0,0,0,1));
        expv(n+31, "s2_rst",    v(1,0,1,0,0,0,1));
        expv(n+36, "s2_start2", v(1,0,1,1,0,0,1));
        expv(n+38, "s2_ready",  v(1,0,1,0,1,0,1));
        expv(n+42, "s2_hold",   v(1,0,1,0,1,0,1));
        expv(n+43, "s2_lost",   RSTV);
        wait_cyc(n+37); cfg_done = 1'b1;
        wait_cyc(n+38); cfg_done = 1'b0;
        wait_cyc(n+40); pll_lock = 1'b0;
        wait_cyc(n+45); pll_lock = 1'b1;
        wait_cyc(n+50);

        // 3: exhaustion; FAULT ignores lock toggling
        restart(n);
        expv(n+24,  "s3_to1",    v(1,1,0,0,0,0,1));
        expv(n+36,  "s3_start2", v(1,0,1,1,0,0,1));
        expv(n+45,  "s3_cfg2",   v(1,0,1,0,0,0,1));
        expv(n+46,  "s3_fault",  v(1,1,0,0,0,1,2));
        expv(n+100, "s3_hold",   v(1,1,0,0,0,1,2));
        expv(n+148, "s3_hold2",  v(1,1,0,0,0,1,2));
        wait_cyc(n+47);
        for (int i = 0; i < 100; i++) begin
            pll_lock = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        pll_lock = 1'b1;
        wait_cyc(n+150);

        // 4: lock loss in RST_WAIT (coincides with its timer expiry), relock
        restart(n);
        expv(n+6, "s4_rstwait", v(1,0,0,0,0,0,0));
        expv(n+9, "s4_lost",    RSTV);
        wait_cyc(n+6); pll_lock = 1'b0;
        wait_cyc(n+12); pll_lock = 1'b1; n = cyc + 1;
        expv(n+1,  "s4_pre",   RSTV);
        expv(n+2,  "s4_xclk",  v(1,1,0,0,0,0,0));
        expv(n+6,  "s4_pwdn",  v(1,0,0,0,0,0,0));
        expv(n+9,  "s4_rst",   v(1,0,1,0,0,0,0));
        expv(n+14, "s4_start", v(1,0,1,1,0,0,0));
        wait_cyc(n+16);

        // 5: stray cfg_done in SCCB_WAIT ignored; cfg_done on timeout wins
        restart(n);
        expv(n+11, "s5_stray",  v(1,0,1,0,0,0,0));
        expv(n+14, "s5_start",  v(1,0,1,1,0,0,0));
        expv(n+23, "s5_wait",   v(1,0,1,0,0,0,0));
        expv(n+24, "s5_prio",   v(1,0,1,0,1,0,0));
        wait_cyc(n+10); cfg_done = 1'b1;
        wait_cyc(n+11); cfg_done = 1'b0;
        wait_cyc(n+23); cfg_done = 1'b1;
        wait_cyc(n+24); cfg_done = 1'b0;
        wait_cyc(n+26);

        // 6: reset on the edge cfg_start would fire, and reset during CFG
        restart(n);
        expv(n+13, "s6_sccb",   v(1,0,1,0,0,0,0));
        expv(n+14, "s6_rst",    RSTV);
        expv(n+15, "s6_nopulse", RSTV);
        wait_cyc(n+13); rst_n = 1'b0;
        wait_cyc(n+14); rst_n = 1'b1; n = cyc + 1;
        expv(n+14, "s6_start",  v(1,0,1,1,0,0,0));
        expv(n+16, "s6_cfg",    v(1,0,1,0,0,0,0));
        expv(n+17, "s6_rstcfg", RSTV);
        expv(n+18, "s6_idle",   RSTV);
        wait_cyc(n+16); rst_n = 1'b0;
        wait_cyc(n+17); rst_n = 1'b1;
        wait_cyc(n+20);

        // Anything left in the scoreboard never came due.
        foreach (sb[i]) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: pending, want %b", sb[i].tag, sb[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
